// File: rtl/psram_rom_loader.sv
// ---------------------------------------------------------------------------
// psram_rom_loader
//
// Boot-time image loader placed in front of the PSRAM byte controller.
// A ROM image arrives as a byte stream over valid/ready and is written
// sequentially into PSRAM starting at BASE_ADDR. When VERIFY is set, the
// image is then read back and its additive (mod-256) checksum is compared
// with the checksum of the bytes written. cart_enable rises only once the
// image is in place and good.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   start, image_len    load request pulse and image byte count (0 = empty)
//   src_valid/ready     byte stream from the flash/UART reader, src_data byte
//   psram_*_req         one-cycle read/write requests, psram_addr/psram_wdata
//   psram_rdata/valid   returned read byte, valid for one cycle
//   psram_busy          byte controller busy
//   loading             high while a load/verify is in progress
//   cart_enable         high once the image is loaded (and verified)
//   error, err_code     failure flag; 1 = ack timeout, 2 = checksum mismatch
//   byte_count          bytes written (load phase) / read (verify phase)
// ---------------------------------------------------------------------------
module psram_rom_loader #(
  parameter logic [21:0] BASE_ADDR   = 22'h000000,
  parameter bit          VERIFY      = 1'b1,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [21:0] image_len,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic        psram_read_req,
  output logic        psram_write_req,
  output logic [21:0] psram_addr,
  output logic [7:0]  psram_wdata,
  input  logic [7:0]  psram_rdata,
  input  logic        psram_data_valid,
  input  logic        psram_busy,
  output logic        loading,
  output logic        cart_enable,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [21:0] byte_count
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  // Last value of the ack counter before giving up; the counter starts at 0
  // in the request-pulse cycle, so ACK_TIMEOUT cycles are examined in total.
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ACK  = 2'd1;
  localparam logic [1:0] ERR_SUM  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_SRC,
    S_WR_REQ,
    S_WR_ACK,
    S_WR_END,
    S_RD_REQ,
    S_RD_ACK,
    S_RD_DATA,
    S_CHECK,
    S_FINISH,
    S_DONE,
    S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [21:0]    len_q, len_d;
  logic [21:0]    cnt_q, cnt_d;
  logic [7:0]     sum_wr_q, sum_wr_d;
  logic [7:0]     sum_rd_q, sum_rd_d;
  logic [7:0]     byte_q, byte_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [21:0]    addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic           wr_req_q, wr_req_d;
  logic           rd_req_q, rd_req_d;
  logic           src_ready_q, src_ready_d;
  logic           loading_q, loading_d;
  logic           cart_q, cart_d;
  logic           err_q, err_d;
  logic [1:0]     code_q, code_d;

  logic [21:0]    cnt_inc;

  assign cnt_inc = cnt_q + 22'd1;

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_wr_d    = sum_wr_q;
    sum_rd_d    = sum_rd_q;
    byte_d      = byte_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_req_d    = 1'b0;
    rd_req_d    = 1'b0;
    src_ready_d = 1'b0;
    loading_d   = loading_q;
    cart_d      = cart_q;
    err_d       = err_q;
    code_d      = code_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          len_d     = image_len;
          cnt_d     = 22'd0;
          sum_wr_d  = 8'd0;
          sum_rd_d  = 8'd0;
          tmo_d     = '0;
          code_d    = ERR_NONE;
          err_d     = 1'b0;
          cart_d    = 1'b0;
          loading_d = 1'b1;
          if (image_len == 22'd0) begin
            state_d = S_FINISH;
          end else begin
            state_d     = S_LOAD_SRC;
            src_ready_d = 1'b1;
          end
        end
      end

      // src_ready is a registered copy of "state is LOAD_SRC"
      S_LOAD_SRC: begin
        src_ready_d = 1'b1;
        if (src_valid) begin
          byte_d      = src_data;
          sum_wr_d    = sum_wr_q + src_data;
          src_ready_d = 1'b0;
          state_d     = S_WR_REQ;
        end
      end

      S_WR_REQ: begin
        if (!psram_busy) begin
          wr_req_d = 1'b1;
          addr_d   = BASE_ADDR + cnt_q;
          wdata_d  = byte_q;
          tmo_d    = '0;
          state_d  = S_WR_ACK;
        end
      end

      S_WR_ACK: begin
        if (psram_busy) begin
          state_d = S_WR_END;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = S_ERROR;
          err_d     = 1'b1;
          code_d    = ERR_ACK;
          loading_d = 1'b0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_WR_END: begin
        if (!psram_busy) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            if (VERIFY) begin
              // byte_count restarts to track bytes read back
              cnt_d   = 22'd0;
              state_d = S_RD_REQ;
            end else begin
              state_d = S_FINISH;
            end
          end else begin
            state_d     = S_LOAD_SRC;
            src_ready_d = 1'b1;
          end
        end
      end

      S_RD_REQ: begin
        if (!psram_busy) begin
          rd_req_d = 1'b1;
          addr_d   = BASE_ADDR + cnt_q;
          tmo_d    = '0;
          state_d  = S_RD_ACK;
        end
      end

      // A controller may return the byte before busy is observed; accept it
      // here as both the acknowledge and the data.
      S_RD_ACK: begin
        if (psram_data_valid) begin
          sum_rd_d = sum_rd_q + psram_rdata;
          cnt_d    = cnt_inc;
          state_d  = (cnt_inc == len_q) ? S_CHECK : S_RD_REQ;
        end else if (psram_busy) begin
          state_d = S_RD_DATA;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = S_ERROR;
          err_d     = 1'b1;
          code_d    = ERR_ACK;
          loading_d = 1'b0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_RD_DATA: begin
        if (psram_data_valid) begin
          sum_rd_d = sum_rd_q + psram_rdata;
          cnt_d    = cnt_inc;
          state_d  = (cnt_inc == len_q) ? S_CHECK : S_RD_REQ;
        end
      end

      S_CHECK: begin
        if (sum_rd_q == sum_wr_q) begin
          state_d = S_FINISH;
        end else begin
          state_d   = S_ERROR;
          err_d     = 1'b1;
          code_d    = ERR_SUM;
          loading_d = 1'b0;
        end
      end

      S_FINISH: begin
        state_d   = S_DONE;
        cart_d    = 1'b1;
        loading_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= 22'd0;
      cnt_q       <= 22'd0;
      sum_wr_q    <= 8'd0;
      sum_rd_q    <= 8'd0;
      byte_q      <= 8'd0;
      tmo_q       <= '0;
      addr_q      <= 22'd0;
      wdata_q     <= 8'd0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      src_ready_q <= 1'b0;
      loading_q   <= 1'b0;
      cart_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_wr_q    <= sum_wr_d;
      sum_rd_q    <= sum_rd_d;
      byte_q      <= byte_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      src_ready_q <= src_ready_d;
      loading_q   <= loading_d;
      cart_q      <= cart_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign src_ready       = src_ready_q;
  assign psram_write_req = wr_req_q;
  assign psram_read_req  = rd_req_q;
  assign psram_addr      = addr_q;
  assign psram_wdata     = wdata_q;
  assign loading         = loading_q;
  assign cart_enable     = cart_q;
  assign error           = err_q;
  assign err_code        = code_q;
  assign byte_count      = cnt_q;

endmodule
